// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage WISC-SP20 pipeline: hazard detection,
// branch flush, memory stalls, HALT drain and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int FWD   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       rs_id,
  input  logic [2:0]       rt_id,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic             halt_id,
  input  logic [2:0]       rd_ex,
  input  logic             reg_write_ex,
  input  logic             mem_read_ex,
  input  logic [2:0]       rd_mem,
  input  logic             reg_write_mem,
  input  logic             branch_taken_ex,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_write_en,
  output logic             idex_flush,
  output logic             exmem_write_en,
  output logic             memwb_write_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             r_halted;

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_ld_use;
  logic w_raw;
  logic w_run_dmem;
  logic w_run_branch;
  logic w_run_raw;
  logic w_run_halt;
  logic w_run_imem;
  logic w_stall_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Write-before-read register file: only the EX and MEM producers matter.
  assign w_hit_ex  = reg_write_ex &
                     ((rs_used_id & (rs_id == rd_ex)) | (rt_used_id & (rt_id == rd_ex)));
  assign w_hit_mem = reg_write_mem &
                     ((rs_used_id & (rs_id == rd_mem)) | (rt_used_id & (rt_id == rd_mem)));
  assign w_ld_use  = w_hit_ex & mem_read_ex;
  assign w_raw     = (FWD != 0) ? w_ld_use : (w_hit_ex | w_hit_mem);

  // One-hot decode of the RUN-state priority chain.
  assign w_run_dmem   = (r_state == RUN) & dmem_stall;
  assign w_run_branch = (r_state == RUN) & ~dmem_stall & branch_taken_ex;
  assign w_run_raw    = (r_state == RUN) & ~dmem_stall & ~branch_taken_ex & w_raw;
  assign w_run_halt   = (r_state == RUN) & ~dmem_stall & ~branch_taken_ex & ~w_raw & halt_id;
  assign w_run_imem   = (r_state == RUN) & ~dmem_stall & ~branch_taken_ex & ~w_raw &
                        ~halt_id & imem_stall;

  assign w_stall_evt = w_run_dmem | w_run_raw | w_run_imem |
                       ((r_state == DRAIN) & dmem_stall);

  always_comb begin
    pc_write_en    = 1'b0;
    ifid_write_en  = 1'b0;
    ifid_flush     = 1'b0;
    idex_write_en  = 1'b0;
    idex_flush     = 1'b0;
    exmem_write_en = 1'b0;
    memwb_write_en = 1'b0;
    unique case (r_state)
      INIT: begin
        ifid_write_en  = 1'b1;
        ifid_flush     = 1'b1;
        idex_write_en  = 1'b1;
        idex_flush     = 1'b1;
        exmem_write_en = 1'b1;
        memwb_write_en = 1'b1;
      end
      RUN: begin
        if (w_run_dmem) begin
          pc_write_en = 1'b0;
        end else if (w_run_branch) begin
          pc_write_en    = 1'b1;
          ifid_write_en  = 1'b1;
          ifid_flush     = 1'b1;
          idex_write_en  = 1'b1;
          idex_flush     = 1'b1;
          exmem_write_en = 1'b1;
          memwb_write_en = 1'b1;
        end else if (w_run_raw) begin
          idex_write_en  = 1'b1;
          idex_flush     = 1'b1;
          exmem_write_en = 1'b1;
          memwb_write_en = 1'b1;
        end else if (w_run_imem) begin
          ifid_write_en  = 1'b1;
          ifid_flush     = 1'b1;
          idex_write_en  = 1'b1;
          exmem_write_en = 1'b1;
          memwb_write_en = 1'b1;
        end else begin
          // Normal advance; a decoded HALT also just moves on into ID/EX.
          pc_write_en    = 1'b1;
          ifid_write_en  = 1'b1;
          idex_write_en  = 1'b1;
          exmem_write_en = 1'b1;
          memwb_write_en = 1'b1;
        end
      end
      DRAIN: begin
        if (!dmem_stall) begin
          idex_write_en  = 1'b1;
          idex_flush     = 1'b1;
          exmem_write_en = 1'b1;
          memwb_write_en = 1'b1;
        end
      end
      HALTED: begin
        pc_write_en = 1'b0;
      end
      default: begin
        pc_write_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= INIT;
      r_drain_cnt    <= 2'd0;
      r_stall_cycles <= '0;
      r_halted       <= 1'b0;
    end else begin
      if (w_stall_evt) begin
        r_stall_cycles <= sat_inc(r_stall_cycles);
      end
      unique case (r_state)
        INIT: r_state <= RUN;
        RUN: begin
          if (w_run_halt) begin
            r_state     <= DRAIN;
            r_drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          if (!dmem_stall) begin
            if (r_drain_cnt == 2'd1) begin
              r_state     <= HALTED;
              r_halted    <= 1'b1;
              r_drain_cnt <= 2'd0;
            end else begin
              r_drain_cnt <= r_drain_cnt - 2'd1;
            end
          end
        end
        HALTED: r_state <= HALTED;
        default: r_state <= INIT;
      endcase
    end
  end

  assign halted       = r_halted;
  assign stall_cycles = r_stall_cycles;

endmodule
